// File: rtl/apb_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fabric
//  Description : Single-master APB interconnect. It decodes the master
//                address against per-slot BASE/MASK windows, sequences the
//                selected slave through its setup and access phases, and
//                returns a registered response to the master. An address
//                that matches no slot gets an immediate error response.
//                Optional feature: define APB_FABRIC_TIMEOUT_EN to bound the
//                slave access phase to TIMEOUT cycles, after which the
//                access ends with a forced error.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_fabric #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NSLAVES    = 4,
    // Slot 0 is the rightmost (least significant) word of each vector.
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] BASE =
        {32'h8000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] MASK =
        {32'h8000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         paddr,
    input  logic [DATA_WIDTH-1:0]         pdata,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [3:0]                    pstb,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pready,
    output logic                          perr,
    output logic [NSLAVES-1:0]            s_sel,
    output logic [NSLAVES-1:0]            s_enable,
    input  logic [NSLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NSLAVES-1:0]            s_ready,
    input  logic [NSLAVES-1:0]            s_perr
);

    localparam int IDXW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SSETUP  = 3'd1;
    localparam logic [2:0] S_SACCESS = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_DERR    = 3'd4;

    logic [2:0]            r_state;
    logic [IDXW-1:0]       r_idx;
    logic [NSLAVES-1:0]    r_sel;
    logic [NSLAVES-1:0]    r_enable;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_perr;

    logic                  w_hit;
    logic [IDXW-1:0]       w_hit_idx;
    logic [NSLAVES-1:0]    w_hit_onehot;
    logic [NSLAVES-1:0]    w_idx_onehot;
    logic [DATA_WIDTH-1:0] w_slv_rdata;
    logic                  w_slv_ready;
    logic                  w_slv_err;

`ifdef APB_FABRIC_TIMEOUT_EN
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNTW-1:0]       r_cnt;
`else
    // Without the timeout feature the limit has no effect.
    localparam int c_timeout_unused = TIMEOUT;
`endif

    // Write data, strobes and direction reach the slaves outside this block.
    logic w_unused_passthru;
    assign w_unused_passthru = ^{pdata, pwrite, pstb};

    // Address decode: scan from the top so the lowest matching slot wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((paddr & MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_hit     = 1'b1;
                w_hit_idx = i[IDXW-1:0];
            end
        end
    end

    assign w_hit_onehot = NSLAVES'(1) << w_hit_idx;
    assign w_idx_onehot = NSLAVES'(1) << r_idx;

    // Only the latched slot's response is ever looked at.
    assign w_slv_rdata = s_rdata[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_slv_ready = s_ready[r_idx];
    assign w_slv_err   = s_perr[r_idx];

    // Transfer sequencer; every master and slave output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_sel    <= '0;
            r_enable <= '0;
            r_prdata <= '0;
            r_pready <= 1'b0;
            r_perr   <= 1'b0;
`ifdef APB_FABRIC_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        r_idx <= w_hit_idx;
                        if (w_hit) begin
                            r_state <= S_SSETUP;
                            r_sel   <= w_hit_onehot;
                        end else begin
                            r_state  <= S_DERR;
                            r_pready <= 1'b1;
                            r_perr   <= 1'b1;
                        end
                    end
                end
                S_SSETUP: begin
                    if (!psel) begin
                        r_state <= S_IDLE;
                        r_sel   <= '0;
                    end else begin
                        r_state  <= S_SACCESS;
                        r_enable <= w_idx_onehot;
`ifdef APB_FABRIC_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                S_SACCESS: begin
                    if (!psel) begin
                        // Master walked away: drop the slave, no response.
                        r_state  <= S_IDLE;
                        r_sel    <= '0;
                        r_enable <= '0;
                    end else if (w_slv_ready) begin
                        r_state  <= S_RESP;
                        r_sel    <= '0;
                        r_enable <= '0;
                        r_pready <= 1'b1;
                        r_prdata <= w_slv_rdata;
                        r_perr   <= w_slv_err;
                    end
`ifdef APB_FABRIC_TIMEOUT_EN
                    else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
                        r_state  <= S_RESP;
                        r_sel    <= '0;
                        r_enable <= '0;
                        r_pready <= 1'b1;
                        r_prdata <= '0;
                        r_perr   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
`endif
                end
                S_RESP, S_DERR: begin
                    r_state  <= S_IDLE;
                    r_pready <= 1'b0;
                    r_perr   <= 1'b0;
                    r_prdata <= '0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_sel    <= '0;
                    r_enable <= '0;
                    r_pready <= 1'b0;
                    r_perr   <= 1'b0;
                    r_prdata <= '0;
                end
            endcase
        end
    end

    assign prdata   = r_prdata;
    assign pready   = r_pready;
    assign perr     = r_perr;
    assign s_sel    = r_sel;
    assign s_enable = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_apb_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_fabric
//  Description : Self-checking bench for apb_fabric. Stimulus queues the
//                expected master response; a monitor compares it whenever
//                pready is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_fabric;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
`ifdef APB_FABRIC_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   paddr = '0;
    logic [DW-1:0]   pdata = '0;
    logic            psel = 1'b0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [3:0]      pstb = '0;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            perr;
    logic [NS-1:0]   s_sel;
    logic [NS-1:0]   s_enable;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]   s_ready;
    logic [NS-1:0]   s_perr;

    // Slave models: non-target slots always assert ready and error as noise.
    logic [NS-1:0]   tgt_mask = '0;
    logic            rdy_on = 1'b0;
    logic            err_on = 1'b0;
    int              rdy_delay = 0;
    int              acc_cnt = 0;

    assign s_ready = ~tgt_mask | ((rdy_on && acc_cnt >= rdy_delay) ? tgt_mask : '0);
    assign s_perr  = ~tgt_mask | (err_on ? tgt_mask : '0);
    assign s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};

    apb_fabric #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NSLAVES    (NS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .paddr    (paddr),
        .pdata    (pdata),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pstb     (pstb),
        .prdata   (prdata),
        .pready   (pready),
        .perr     (perr),
        .s_sel    (s_sel),
        .s_enable (s_enable),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .s_perr   (s_perr)
    );

    always #5 clk = ~clk;

    // Counts access-phase cycles so a slave can answer after a chosen delay.
    always @(posedge clk) acc_cnt <= (|s_enable) ? acc_cnt + 1 : 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: response scoreboard plus per-cycle output invariants.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(s_sel) > 1) begin
                errors++;
                $display("FAIL onehot_sel: got s_sel=%b expected at most one bit", s_sel);
            end
            if (pready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pready: got pready=1 prdata=%h perr=%b expected no response", prdata, perr);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (prdata !== mon_e.data || perr !== mon_e.err) begin
                        errors++;
                        $display("FAIL response: got prdata=%h perr=%b expected prdata=%h perr=%b",
                                 prdata, perr, mon_e.data, mon_e.err);
                    end
                end
            end else begin
                checks++;
                if (prdata !== '0 || perr !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got prdata=%h perr=%b expected 0/0", prdata, perr);
                end
            end
        end
    end

    // Full transfer; starts and ends just after a rising edge.
    task automatic do_xfer(input string name, input logic [31:0] addr, input logic wr,
                           input logic [3:0] strb, input logic [3:0] tmask, input int delay,
                           input logic en_rdy, input logic en_err, input logic [3:0] exp_sel,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int  n;
        bit  seen;
        tgt_mask  = tmask;
        rdy_delay = delay;
        rdy_on    = en_rdy;
        err_on    = en_err;
        paddr     = addr;
        pwrite    = wr;
        pstb      = strb;
        pdata     = ~addr;
        psel      = 1'b1;
        penable   = 1'b0;
        sb_q.push_back('{exp_data, exp_err});
        seen = 1'b0;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 2) chk({name, "_sel"}, 32'(s_sel), 32'(exp_sel));
            if (n == 3 && exp_sel != 4'd0) chk({name, "_enable"}, 32'(s_enable), 32'(exp_sel));
            if (pready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            penable = 1'b1;
        end
        checks++;
        if (!seen || n != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (seen=%0d) expected %0d", name, n, seen, exp_lat);
        end
        if (seen) chk({name, "_desel"}, {24'd0, s_sel, s_enable}, 32'd0);
        else if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Master abandons the transfer after wait_cycles edges past setup.
    task automatic abort_xfer(input string name, input logic [31:0] addr, input logic [3:0] tmask,
                              input int wait_cycles);
        tgt_mask = tmask;
        rdy_on   = 1'b0;
        err_on   = 1'b0;
        paddr    = addr;
        pwrite   = 1'b0;
        pstb     = 4'hF;
        psel     = 1'b1;
        penable  = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        repeat (wait_cycles) @(posedge clk);
        #1;
        chk({name, "_active_enable"}, 32'(s_enable), 32'(tmask));
        chk({name, "_no_pready"}, 32'(pready), 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_released"}, {24'd0, s_sel, s_enable}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pready", 32'(pready), 32'd0);
        chk("reset_perr", 32'(perr), 32'd0);
        chk("reset_prdata", prdata, 32'd0);
        chk("reset_sel_enable", {24'd0, s_sel, s_enable}, 32'd0);
        rst = 1'b0;

        // First transfer is presented immediately after reset release.
        do_xfer("rd_slot1", 32'h1000_0040, 1'b0, 4'hF, 4'b0010, 0, 1'b1, 1'b0,
                4'b0010, 32'hDEAD_BEEF, 1'b0, 4);
        do_xfer("wr_slot2_err", 32'h2000_0004, 1'b1, 4'b0011, 4'b0100, 0, 1'b1, 1'b1,
                4'b0100, 32'h2222_2222, 1'b1, 4);
        do_xfer("unmapped", 32'h3000_0000, 1'b0, 4'hF, 4'b0000, 0, 1'b0, 1'b0,
                4'b0000, 32'h0000_0000, 1'b1, 2);
        do_xfer("rd_slot3", 32'h9000_0000, 1'b0, 4'hF, 4'b1000, 0, 1'b1, 1'b0,
                4'b1000, 32'h3333_3333, 1'b0, 4);
        do_xfer("rd_slot0", 32'h0000_0010, 1'b0, 4'hF, 4'b0001, 0, 1'b1, 1'b0,
                4'b0001, 32'h1111_0000, 1'b0, 4);
        do_xfer("rd_slot1_wait3", 32'h1000_0100, 1'b0, 4'hF, 4'b0010, 3, 1'b1, 1'b0,
                4'b0010, 32'hDEAD_BEEF, 1'b0, 7);

`ifdef APB_FABRIC_TIMEOUT_EN
        do_xfer("timeout_slot0", 32'h0000_0020, 1'b0, 4'hF, 4'b0001, 0, 1'b0, 1'b0,
                4'b0001, 32'h0000_0000, 1'b1, 11);
        abort_xfer("abort_slot0", 32'h0000_0030, 4'b0001, 3);
`else
        abort_xfer("hang_then_abort", 32'h0000_0030, 4'b0001, 1000);
`endif

        // Asynchronous reset in the middle of an access phase.
        tgt_mask = 4'b1000;
        rdy_on   = 1'b0;
        err_on   = 1'b0;
        paddr    = 32'h9000_0000;
        psel     = 1'b1;
        penable  = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_reset_enable", 32'(s_enable), 32'h8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_sel_enable", {24'd0, s_sel, s_enable}, 32'd0);
        chk("async_reset_resp", {30'd0, pready, perr}, 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_xfer("post_reset_slot3", 32'h9000_0000, 1'b0, 4'hF, 4'b1000, 0, 1'b1, 1'b0,
                4'b1000, 32'h3333_3333, 1'b0, 4);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
